// File: rtl/hdmi_quad_pixel_mux_pkg.sv
// Shared definitions for the quad-FIFO HDMI pixel mux: FSM encoding, quadrant indices, colours.
package hdmi_quad_pixel_mux_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_RUN     = 2'd2
   } mux_state_t;

   localparam int QUAD_A = 0;
   localparam int QUAD_B = 1;
   localparam int QUAD_C = 2;
   localparam int QUAD_D = 3;

   localparam logic [23:0] BLANK_RGB_DFLT = 24'h000000;
   localparam logic [23:0] SEAM_RGB       = 24'hFF0000;

endpackage

// File: rtl/hdmi_align_delay.sv
// N-stage shift register used to line sync, DE and per-quadrant flags up with FIFO read data.
// Latency N cycles; no backpressure (free-running pixel path).
module hdmi_align_delay #(
   parameter int W = 1,
   parameter int N = 1
) (
   input  logic         hdmi_clk,
   input  logic         sys_rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sr [N];

   always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < N; i++) sr[i] <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
      end
   end

   assign q = sr[N-1];

endmodule

// File: rtl/hdmi_quad_pixel_mux.sv
// Selects one of four quadrant FIFOs per pixel, gates to blank until a clean frame start, flags underflow.
// Latency RD_LAT+1 for sync, DE and pixel; no backpressure. Optional seam overlay: HDMI_QUAD_SEAM_EN.
module hdmi_quad_pixel_mux
   import hdmi_quad_pixel_mux_pkg::*;
#(
   parameter int                 DATA_W    = 24,
   parameter int                 RD_LAT    = 1,
   parameter logic [DATA_W-1:0]  BLANK_RGB = DATA_W'(BLANK_RGB_DFLT)
`ifdef HDMI_QUAD_SEAM_EN
   ,
   parameter int                 H_ACTIVE  = 1920,
   parameter int                 V_ACTIVE  = 1080
`endif
) (
   input  logic              hdmi_clk,
   input  logic              sys_rst_n,
   input  logic              data_rd_valid,
   input  logic              hdmi_hs_in,
   input  logic              hdmi_vs_in,
   input  logic              hdmi_de_in,
   input  logic              dma_rd_A_rden,
   input  logic              dma_rd_B_rden,
   input  logic              dma_rd_C_rden,
   input  logic              dma_rd_D_rden,
   input  logic              dma_rd_A_empty,
   input  logic              dma_rd_B_empty,
   input  logic              dma_rd_C_empty,
   input  logic              dma_rd_D_empty,
   input  logic [DATA_W-1:0] dma_rd_A_q,
   input  logic [DATA_W-1:0] dma_rd_B_q,
   input  logic [DATA_W-1:0] dma_rd_C_q,
   input  logic [DATA_W-1:0] dma_rd_D_q,
   output logic              hdmi_hs_out,
   output logic              hdmi_vs_out,
   output logic              hdmi_de_out,
   output logic [DATA_W-1:0] hdmi_rgb_out,
   output logic [3:0]        underflow_flag,
   output logic [15:0]       underflow_frames
);

   mux_state_t        state, state_nxt;
   logic [3:0]        rden_vec, empty_vec, uf_pend;
   logic [3:0]        rden_d, uf_d;
   logic              hs_d, vs_d, de_d;
   logic              vs_prev, vs_rise, vs_al_rise, run_gate;
   logic [DATA_W-1:0] pix_sel;

   assign rden_vec[QUAD_A]  = dma_rd_A_rden;
   assign rden_vec[QUAD_B]  = dma_rd_B_rden;
   assign rden_vec[QUAD_C]  = dma_rd_C_rden;
   assign rden_vec[QUAD_D]  = dma_rd_D_rden;
   assign empty_vec[QUAD_A] = dma_rd_A_empty;
   assign empty_vec[QUAD_B] = dma_rd_B_empty;
   assign empty_vec[QUAD_C] = dma_rd_C_empty;
   assign empty_vec[QUAD_D] = dma_rd_D_empty;

   assign uf_pend = (state == ST_RUN) ? (rden_vec & empty_vec) : 4'b0000;

   hdmi_align_delay #(.W(11), .N(RD_LAT)) u_align (
      .hdmi_clk  (hdmi_clk),
      .sys_rst_n (sys_rst_n),
      .d         ({hdmi_hs_in, hdmi_vs_in, hdmi_de_in, rden_vec, uf_pend}),
      .q         ({hs_d, vs_d, de_d, rden_d, uf_d})
   );

   assign vs_rise    = hdmi_vs_in & ~vs_prev;
   assign vs_al_rise = vs_d & ~hdmi_vs_out;
   // Gate on the live valid so a dropped data_rd_valid blanks the very next output pixel.
   assign run_gate   = (state == ST_RUN) && data_rd_valid;

   always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state   <= ST_IDLE;
         vs_prev <= 1'b0;
      end else begin
         state   <= state_nxt;
         vs_prev <= hdmi_vs_in;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (data_rd_valid) state_nxt = ST_WAIT_VS;
         ST_WAIT_VS: if (!data_rd_valid) state_nxt = ST_IDLE;
                     else if (vs_rise) state_nxt = ST_RUN;
         ST_RUN:     if (!data_rd_valid) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

`ifdef HDMI_QUAD_SEAM_EN
   localparam int XW = $clog2(H_ACTIVE + 1);
   localparam int YW = $clog2(V_ACTIVE + 1);
   logic [XW-1:0] x_cnt;
   logic [YW-1:0] y_cnt;
   logic          seam_hit;

   always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         x_cnt <= de_d ? x_cnt + 1'b1 : '0;
         if (vs_d) y_cnt <= '0;
         else if (hdmi_de_out && !de_d) y_cnt <= y_cnt + 1'b1;
      end
   end

   assign seam_hit = de_d && (x_cnt == XW'(H_ACTIVE/2 - 1) || x_cnt == XW'(H_ACTIVE/2) ||
                              y_cnt == YW'(V_ACTIVE/2 - 1) || y_cnt == YW'(V_ACTIVE/2));
`endif

   // Non-one-hot read enables are an upstream contract violation: blank, no flag.
   always_comb begin
      pix_sel = BLANK_RGB;
      case (rden_d)
         4'b0001: pix_sel = dma_rd_A_q;
         4'b0010: pix_sel = dma_rd_B_q;
         4'b0100: pix_sel = dma_rd_C_q;
         4'b1000: pix_sel = dma_rd_D_q;
         default: pix_sel = BLANK_RGB;
      endcase
      if (|uf_d) pix_sel = BLANK_RGB;
`ifdef HDMI_QUAD_SEAM_EN
      if (seam_hit) pix_sel = DATA_W'(SEAM_RGB);
`endif
      if (!run_gate) pix_sel = BLANK_RGB;
   end

   always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hdmi_hs_out      <= 1'b0;
         hdmi_vs_out      <= 1'b0;
         hdmi_de_out      <= 1'b0;
         hdmi_rgb_out     <= BLANK_RGB;
         underflow_flag   <= 4'b0000;
         underflow_frames <= 16'd0;
      end else begin
         hdmi_hs_out    <= hs_d;
         hdmi_vs_out    <= vs_d;
         hdmi_de_out    <= de_d;
         hdmi_rgb_out   <= pix_sel;
         // New underflow in the boundary cycle survives the clear and belongs to the new frame.
         underflow_flag <= (vs_al_rise ? 4'b0000 : underflow_flag) | uf_d;
         if (vs_al_rise && (|underflow_flag) && (underflow_frames != 16'hFFFF))
            underflow_frames <= underflow_frames + 16'd1;
      end
   end

endmodule

// File: tb/tb_hdmi_quad_pixel_mux.sv
// Directed bench for hdmi_quad_pixel_mux: reset, pass-through, start gating, quadrant select,
// underflow/frame counting, valid drop and mid-frame reset.
module tb_hdmi_quad_pixel_mux;

   localparam int RD_LAT = 1;
   localparam int LAT    = RD_LAT + 1;

   logic        hdmi_clk = 1'b0;
   logic        sys_rst_n, data_rd_valid;
   logic        hs_in, vs_in, de_in;
   logic [3:0]  rden, empty;
   logic [23:0] qa, qb, qc, qd;
   logic        hs_out, vs_out, de_out;
   logic [23:0] rgb_out;
   logic [3:0]  uf_flag;
   logic [15:0] uf_frames;

   int checks = 0;
   int errors = 0;

   hdmi_quad_pixel_mux #(.DATA_W(24), .RD_LAT(RD_LAT)) dut (
      .hdmi_clk         (hdmi_clk),
      .sys_rst_n        (sys_rst_n),
      .data_rd_valid    (data_rd_valid),
      .hdmi_hs_in       (hs_in),
      .hdmi_vs_in       (vs_in),
      .hdmi_de_in       (de_in),
      .dma_rd_A_rden    (rden[0]),
      .dma_rd_B_rden    (rden[1]),
      .dma_rd_C_rden    (rden[2]),
      .dma_rd_D_rden    (rden[3]),
      .dma_rd_A_empty   (empty[0]),
      .dma_rd_B_empty   (empty[1]),
      .dma_rd_C_empty   (empty[2]),
      .dma_rd_D_empty   (empty[3]),
      .dma_rd_A_q       (qa),
      .dma_rd_B_q       (qb),
      .dma_rd_C_q       (qc),
      .dma_rd_D_q       (qd),
      .hdmi_hs_out      (hs_out),
      .hdmi_vs_out      (vs_out),
      .hdmi_de_out      (de_out),
      .hdmi_rgb_out     (rgb_out),
      .underflow_flag   (uf_flag),
      .underflow_frames (uf_frames)
   );

   always #5 hdmi_clk = ~hdmi_clk;

   task automatic drv(input logic hs, input logic vs, input logic de,
                      input logic [3:0] rd, input logic [3:0] em);
      hs_in = hs; vs_in = vs; de_in = de; rden = rd; empty = em;
   endtask

   task automatic test_reset;
      sys_rst_n = 1'b0; data_rd_valid = 1'b0;
      drv(0, 0, 0, 4'h0, 4'h0);
      qa = 24'h123456; qb = 24'h0; qc = 24'h0; qd = 24'h0;
      repeat (3) @(negedge hdmi_clk);
      checks++; if ({hs_out, vs_out, de_out} !== 3'b000) begin errors++; $display("FAIL reset_sync got %b want 000", {hs_out, vs_out, de_out}); end
      checks++; if (rgb_out !== 24'h000000) begin errors++; $display("FAIL reset_rgb got %h want 000000", rgb_out); end
      checks++; if (uf_flag !== 4'b0000) begin errors++; $display("FAIL reset_flag got %b want 0000", uf_flag); end
      checks++; if (uf_frames !== 16'd0) begin errors++; $display("FAIL reset_frames got %0d want 0", uf_frames); end
      sys_rst_n = 1'b1;
   endtask

   // Not primed: a full mini frame must come out blank with sync/DE delayed by LAT.
   task automatic test_passthrough;
      logic [2:0] s [64];
      logic hs, vs, de;
      for (int k = 0; k < 64 + LAT; k++) begin
         @(negedge hdmi_clk);
         if (k >= LAT) begin
            checks++; if ({hs_out, vs_out, de_out} !== s[k-LAT]) begin errors++; $display("FAIL pass_sync k=%0d got %b want %b", k, {hs_out, vs_out, de_out}, s[k-LAT]); end
            checks++; if (rgb_out !== 24'h000000) begin errors++; $display("FAIL pass_rgb k=%0d got %h want 000000", k, rgb_out); end
         end
         if (k < 64) begin
            hs = (k % 16) < 2;
            vs = k < 3;
            de = ((k % 16) >= 4) && (k >= 8);
            s[k] = {hs, vs, de};
            drv(hs, vs, de, de ? 4'b0001 : 4'b0000, 4'h0);
         end else begin
            drv(0, 0, 0, 4'h0, 4'h0);
         end
      end
   endtask

   task automatic test_start_gating;
      logic [23:0] exp;
      qa = 24'h112233;
      data_rd_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge hdmi_clk);
         checks++; if (rgb_out !== 24'h000000) begin errors++; $display("FAIL wait_vs_blank k=%0d got %h want 000000", k, rgb_out); end
         drv(0, 0, 1, 4'b0001, 4'h0);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge hdmi_clk);
         checks++; if (rgb_out !== 24'h000000) begin errors++; $display("FAIL vs_edge_blank k=%0d got %h want 000000", k, rgb_out); end
         drv(0, k < 2, 0, 4'h0, 4'h0);
      end
      for (int j = 0; j < LAT + 5; j++) begin
         @(negedge hdmi_clk);
         exp = (j - LAT >= 0 && j - LAT < 3) ? 24'h112233 : 24'h000000;
         checks++; if (rgb_out !== exp) begin errors++; $display("FAIL first_pixel j=%0d got %h want %h", j, rgb_out, exp); end
         drv(0, 0, j < 3, (j < 3) ? 4'b0001 : 4'b0000, 4'h0);
      end
   endtask

   task automatic test_quadrants;
      logic [3:0]  rd_t [9];
      logic [23:0] ex_t [9];
      qa = 24'h0000AA; qb = 24'h00AA00; qc = 24'hAA0000; qd = 24'hAAAAAA;
      rd_t = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0011, 4'b1000};
      ex_t = '{24'h0000AA, 24'h0000AA, 24'h00AA00, 24'h00AA00, 24'hAA0000, 24'hAAAAAA,
               24'h000000, 24'h000000, 24'hAAAAAA};
      for (int k = 0; k < 9 + LAT; k++) begin
         @(negedge hdmi_clk);
         if (k >= LAT) begin
            checks++; if (rgb_out !== ex_t[k-LAT]) begin errors++; $display("FAIL quad k=%0d got %h want %h", k - LAT, rgb_out, ex_t[k-LAT]); end
         end
         if (k < 9) drv(0, 0, 1, rd_t[k], 4'h0);
         else       drv(0, 0, 0, 4'h0, 4'h0);
      end
   endtask

   task automatic test_underflow;
      logic [3:0]  rd_t [4];
      logic [3:0]  em_t [4];
      logic [23:0] ex_t [4];
      rd_t = '{4'b0100, 4'b0100, 4'b0100, 4'b0100};
      em_t = '{4'b0000, 4'b0100, 4'b0000, 4'b0001};
      ex_t = '{24'hAA0000, 24'h000000, 24'hAA0000, 24'hAA0000};
      for (int k = 0; k < 4 + LAT; k++) begin
         @(negedge hdmi_clk);
         if (k >= LAT) begin
            checks++; if (rgb_out !== ex_t[k-LAT]) begin errors++; $display("FAIL uf_pixel k=%0d got %h want %h", k - LAT, rgb_out, ex_t[k-LAT]); end
         end
         if (k < 4) drv(0, 0, 1, rd_t[k], em_t[k]);
         else       drv(0, 0, 0, 4'h0, 4'h0);
      end
      repeat (2) @(negedge hdmi_clk);
      checks++; if (uf_flag !== 4'b0100) begin errors++; $display("FAIL uf_flag_set got %b want 0100", uf_flag); end
      checks++; if (uf_frames !== 16'd0) begin errors++; $display("FAIL uf_frames_pre got %0d want 0", uf_frames); end
      for (int k = 0; k < 6; k++) begin
         drv(0, k < 3, 0, 4'h0, 4'h0);
         @(negedge hdmi_clk);
      end
      checks++; if (uf_flag !== 4'b0000) begin errors++; $display("FAIL uf_flag_clear got %b want 0000", uf_flag); end
      checks++; if (uf_frames !== 16'd1) begin errors++; $display("FAIL uf_frames_one got %0d want 1", uf_frames); end
      // Underflow on the same cycle as the frame edge: flag survives, count unchanged.
      for (int k = 0; k < 6; k++) begin
         drv(0, k < 3, k == 0, (k == 0) ? 4'b0100 : 4'h0, (k == 0) ? 4'b0100 : 4'h0);
         @(negedge hdmi_clk);
      end
      checks++; if (uf_flag !== 4'b0100) begin errors++; $display("FAIL uf_set_wins got %b want 0100", uf_flag); end
      checks++; if (uf_frames !== 16'd1) begin errors++; $display("FAIL uf_frames_coinc got %0d want 1", uf_frames); end
      for (int k = 0; k < 6; k++) begin
         drv(0, k < 3, 0, 4'h0, 4'h0);
         @(negedge hdmi_clk);
      end
      checks++; if (uf_flag !== 4'b0000) begin errors++; $display("FAIL uf_flag_clear2 got %b want 0000", uf_flag); end
      checks++; if (uf_frames !== 16'd2) begin errors++; $display("FAIL uf_frames_two got %0d want 2", uf_frames); end
   endtask

   task automatic test_valid_drop;
      drv(0, 0, 1, 4'b0001, 4'h0);
      repeat (LAT + 2) @(negedge hdmi_clk);
      checks++; if (rgb_out !== 24'h0000AA) begin errors++; $display("FAIL drop_pre got %h want 0000aa", rgb_out); end
      data_rd_valid = 1'b0;
      @(negedge hdmi_clk);
      checks++; if (rgb_out !== 24'h000000) begin errors++; $display("FAIL drop_next got %h want 000000", rgb_out); end
      repeat (3) @(negedge hdmi_clk);
      data_rd_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge hdmi_clk);
         checks++; if (rgb_out !== 24'h000000) begin errors++; $display("FAIL rearm_wait k=%0d got %h want 000000", k, rgb_out); end
      end
      drv(0, 1, 1, 4'b0001, 4'h0);
      @(negedge hdmi_clk);
      checks++; if (rgb_out !== 24'h000000) begin errors++; $display("FAIL rearm_edge got %h want 000000", rgb_out); end
      drv(0, 0, 1, 4'b0001, 4'h0);
      repeat (3) @(negedge hdmi_clk);
      checks++; if (rgb_out !== 24'h0000AA) begin errors++; $display("FAIL rearm_run got %h want 0000aa", rgb_out); end
      checks++; if (uf_frames !== 16'd2) begin errors++; $display("FAIL rearm_frames got %0d want 2", uf_frames); end
   endtask

   task automatic test_reset_mid;
      sys_rst_n = 1'b0;
      #2;
      checks++; if (rgb_out !== 24'h000000) begin errors++; $display("FAIL midrst_rgb got %h want 000000", rgb_out); end
      checks++; if (uf_frames !== 16'd0) begin errors++; $display("FAIL midrst_frames got %0d want 0", uf_frames); end
      @(negedge hdmi_clk);
      sys_rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge hdmi_clk);
         checks++; if (rgb_out !== 24'h000000) begin errors++; $display("FAIL midrst_wait k=%0d got %h want 000000", k, rgb_out); end
      end
      drv(0, 0, 0, 4'h0, 4'h0);
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_start_gating();
      test_quadrants();
      test_underflow();
      test_valid_drop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hdmi_quad_pixel_mux.md
Name: hdmi_quad_pixel_mux

Overview:
- Downstream of the HDMI timing/read-enable generator.
- Consumes that stage's registered hs/vs/de and the four quadrant read enables (A = top-left, B = top-right, C = bottom-left, D = bottom-right).
- Captures read data from the four DMA read FIFOs, selects the active quadrant, and delays sync/DE to match FIFO read latency. Emits one aligned RGB pixel stream to the HDMI encoder.
- Gates output to black until a clean frame start and flags FIFO underflow per quadrant.

Parameters:
- DATA_W, 24, pixel width (RGB888).
- RD_LAT, 1, FIFO read latency in hdmi_clk cycles (legal 1..3).
- BLANK_RGB, 24'h000000, pixel value driven when gated or underflowing.

Ports:
- hdmi_clk  in  1  pixel clock
- sys_rst_n  in  1  asynchronous active-low reset
- data_rd_valid  in  1  DMA buffers primed; level signal
- hdmi_hs_in  in  1  hsync from timing generator
- hdmi_vs_in  in  1  vsync from timing generator, active high
- hdmi_de_in  in  1  data enable from timing generator
- dma_rd_A_rden..dma_rd_D_rden  in  1 each  quadrant read enables, same cycle as hdmi_de_in
- dma_rd_A_empty..dma_rd_D_empty  in  1 each  FIFO empty flags
- dma_rd_A_q..dma_rd_D_q  in  DATA_W each  FIFO read data, valid RD_LAT cycles after rden
- hdmi_hs_out, hdmi_vs_out, hdmi_de_out  out  1  aligned sync/DE
- hdmi_rgb_out  out  DATA_W  pixel
- underflow_flag  out  4  sticky per-quadrant underflow, bit0 = A .. bit3 = D
- underflow_frames  out  16  frames containing any underflow

Behaviour:
- One clock domain: hdmi_clk. Reset is asynchronous, active-low on sys_rst_n.
- Reset values:
  - All outputs 0.
  - hdmi_rgb_out = BLANK_RGB.
  - FSM in IDLE.
- Latency:
  - hs/vs/de/rden inputs pass through an RD_LAT-stage shift register, then one output register.
  - Total latency from input to hdmi_*_out is RD_LAT+1 cycles, identical for sync, DE and pixel.
- Quadrant select:
  - The delayed one-hot rden vector picks the q input.
  - All rden zero -> BLANK_RGB.
  - More than one bit set -> BLANK_RGB, and error bit 3 of an internal sticky is NOT raised (the upstream guarantees one-hot).
- FSM:
  - IDLE: pixels forced to BLANK_RGB; sync/DE still pass through. When data_rd_valid = 1 -> WAIT_VS.
  - WAIT_VS: pixels blanked. On rising edge of hdmi_vs_in (prev 0, now 1) -> RUN. If data_rd_valid = 0 -> IDLE.
  - RUN: pixels from the selected FIFO. If data_rd_valid falls -> IDLE on the next cycle; blanking takes effect immediately on the aligned output path.
- Underflow:
  - In RUN, rden_X = 1 with empty_X = 1 sets an underflow pending bit for that quadrant, carried through the delay line.
  - The matching output pixel is BLANK_RGB.
  - underflow_flag[X] is sticky.
- Frame boundary:
  - Every vs rising edge clears underflow_flag.
  - If any flag was set at that edge, underflow_frames increments, saturating at 16'hFFFF.
  - If a set and a clear coincide in the same cycle, the set wins.
- Reset mid-frame returns to IDLE; the next output starts only after data_rd_valid and a full vs edge.

Optional Feature:
- HDMI_QUAD_SEAM_EN: adds internal x/y counters, reset by aligned de/vs.
  - A pixel at column H_ACTIVE/2-1 or H_ACTIVE/2, or row V_ACTIVE/2-1 or V_ACTIVE/2, is replaced by 24'hFF0000 in RUN.
  - Adds parameters H_ACTIVE (1920) and V_ACTIVE (1080).
- Without the macro, no counters exist and data passes unmodified.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE = 2'd0, WAIT_VS = 2'd1, RUN = 2'd2).
  - Quadrant index constants A..D = 0..3.
  - BLANK_RGB and seam colour.
- One sub-module: hdmi_align_delay, a parameterised N-stage shift register with async reset, reused for the sync and rden/underflow delay lines.

Test Plan:
- Reset, data_rd_valid = 0, run a full sim frame -> rgb_out stays 000000; hs/vs/de equal inputs delayed 2 cycles (RD_LAT = 1).
- data_rd_valid asserted mid-frame -> pixels blank until the first vs rising edge, then A q = 0x112233 appears exactly 2 cycles after rden_A.
- Four FIFOs return constants 0x0000AA, 0x00AA00, 0xAA0000, 0xAAAAAA -> output quadrants match per rden, seam column 960 switches A->B on the exact cycle.
- empty_C forced high for one pixel -> that pixel = 000000, underflow_flag = 4'b0100, cleared at next vs edge, underflow_frames = 1.
- data_rd_valid dropped during RUN -> blank output the following cycle; reasserted -> waits for the next vs edge before data.
- RD_LAT = 3 build -> same checks with total latency 4.
